// File: rtl/fp16acc_stream.sv
// ---------------------------------------------------------------------------
// fp16acc_stream
//   Sequential FP16 reduction stage. Elements arrive one at a time on a
//   valid/ready stream. Each one is added into a running accumulator through
//   a pipelined FP16 adder. The adder rounds toward zero, flushes denormal
//   inputs and outputs to zero, and follows the IEEE special cases.
//   One sum is emitted per packet. Packets are delimited by i_last.
//
//   Optional feature macro: FP16ACC_FLAGS_EN
//     defined   : o_flags = {nan_seen, inf_seen}. The flags are sticky over the
//                 packet's accumulator updates and are presented with o_sum.
//     undefined : o_flags is tied to 2'b00.
//
//   Ports
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous active-low reset
//     i_vld    in   input element valid
//     o_rdy    out  block can accept an element (ACCEPT state)
//     i_data   in   FP16 element
//     i_last   in   last element of packet, qualified by i_vld
//     o_vld    out  packet sum valid
//     i_rdy    in   downstream accepts the sum
//     o_sum    out  FP16 packet sum
//     o_count  out  element count of the packet, saturating
//     o_flags  out  {nan_seen, inf_seen}
// ---------------------------------------------------------------------------

// fp16add_pipe: combinational FP16 add followed by LATENCY output registers.
// The pipeline has no reset. The consumer must ignore results until fresh
// operands have had LATENCY edges to propagate.
//   i_a, i_b : FP16 operands
//   o_res    : FP16 sum, LATENCY edges after the operands change
module fp16add_pipe #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_res
);
    logic        sa, sb, sx, swap, eff_sub;
    logic [4:0]  ea, eb, ex, dexp;
    logic [9:0]  fa, fb;
    logic [3:0]  dcap, msb, shift;
    logic [13:0] mx, aly, norm;
    logic [27:0] shx;
    logic [14:0] sum;
    logic [9:0]  frac;
    logic [6:0]  exp_w;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [15:0] res_c;

    assign {sa, ea, fa} = i_a;
    assign {sb, eb, fb} = i_b;
    // Denormals are treated as zero.
    assign a_zero = (ea == 5'd0);
    assign b_zero = (eb == 5'd0);
    assign a_inf  = (ea == 5'h1F) && (fa == 10'd0);
    assign b_inf  = (eb == 5'h1F) && (fb == 10'd0);
    assign a_nan  = (ea == 5'h1F) && (fa != 10'd0);
    assign b_nan  = (eb == 5'h1F) && (fb != 10'd0);

    always_comb begin
        swap    = ({eb, fb} > {ea, fa});
        sx      = swap ? sb : sa;
        ex      = swap ? eb : ea;
        mx      = {1'b1, (swap ? fb : fa), 3'b000};
        dexp    = swap ? (eb - ea) : (ea - eb);
        // Shifting by 14 or more moves the whole smaller mantissa into the sticky bits.
        dcap    = (dexp > 5'd14) ? 4'd14 : dexp[3:0];
        shx     = {1'b1, (swap ? fa : fb), 3'b000, 14'd0} >> dcap;
        aly     = {shx[27:15], shx[14] | (|shx[13:0])};
        eff_sub = sa ^ sb;
        sum     = eff_sub ? ({1'b0, mx} - {1'b0, aly}) : ({1'b0, mx} + {1'b0, aly});

        msb = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (sum[i]) msb = 4'(i);
        end
        shift = 4'd13 - msb;
        norm  = sum[13:0] << shift;

        if (sum[14]) begin
            // Carry out: renormalise right by one and truncate (round toward zero).
            frac  = sum[13:4];
            exp_w = {2'b00, ex} + 7'd1;
        end else begin
            frac  = norm[12:3];
            exp_w = {2'b00, ex} - {3'b000, shift};
        end

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            res_c = 16'h7E00;
        end else if (a_inf) begin
            res_c = {sa, 15'h7C00};
        end else if (b_inf) begin
            res_c = {sb, 15'h7C00};
        end else if (a_zero && b_zero) begin
            res_c = {sa & sb, 15'd0};
        end else if (a_zero) begin
            res_c = i_b;
        end else if (b_zero) begin
            res_c = i_a;
        end else if (sum == 15'd0) begin
            res_c = 16'h0000;
        end else if (exp_w[6] || (exp_w == 7'd0)) begin
            res_c = {sx, 15'd0};                 // underflow flushes to signed zero
        end else if (exp_w >= 7'd31) begin
            res_c = {sx, 5'h1F, 10'd0};          // overflow saturates to infinity
        end else begin
            res_c = {sx, exp_w[4:0], frac};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic [15:0] stage_q;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) stage_q <= res_c;
            end else begin : g_next
                always_ff @(posedge clk) stage_q <= g_stage[gi-1].stage_q;
            end
        end
    endgenerate

    assign o_res = g_stage[LATENCY-1].stage_q;
endmodule

module fp16acc_stream #(
    parameter int ADD_LATENCY = 1,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_vld,
    output logic                   o_rdy,
    input  logic [15:0]            i_data,
    input  logic                   i_last,
    output logic                   o_vld,
    input  logic                   i_rdy,
    output logic [15:0]            o_sum,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic [1:0]             o_flags
);
    typedef enum logic [1:0] {S_ACCEPT, S_WAIT, S_OUT} state_t;

    localparam logic [2:0] LAT3 = 3'(ADD_LATENCY);

    state_t                 state_q, state_d;
    logic [15:0]            acc_q, acc_d, op_a_q, op_a_d, op_b_q, op_b_d;
    logic [15:0]            sum_q, sum_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, count_q, count_d;
    logic [2:0]             wcnt_q, wcnt_d;
    logic                   last_q, last_d;
    logic [15:0]            add_res;

    fp16add_pipe #(.LATENCY(ADD_LATENCY)) u_add (
        .clk   (clk),
        .i_a   (op_a_q),
        .i_b   (op_b_q),
        .o_res (add_res)
    );

`ifdef FP16ACC_FLAGS_EN
    logic [1:0] pflags_q, pflags_d, oflags_q, oflags_d;
    logic [1:0] res_flags;
    assign res_flags = {(&add_res[14:10]) && (|add_res[9:0]),
                        (&add_res[14:10]) && (add_res[9:0] == 10'd0)};
    assign o_flags   = oflags_q;
`else
    assign o_flags   = 2'b00;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        wcnt_d  = wcnt_q;
        last_d  = last_q;
        o_rdy   = 1'b0;
`ifdef FP16ACC_FLAGS_EN
        pflags_d = pflags_q;
        oflags_d = oflags_q;
`endif
        case (state_q)
            S_ACCEPT: begin
                o_rdy = 1'b1;
                if (i_vld) begin
                    op_a_d  = acc_q;
                    op_b_d  = i_data;
                    last_d  = i_last;
                    wcnt_d  = LAT3;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q != 3'd0) begin
                    wcnt_d = wcnt_q - 3'd1;
                end else begin
                    // The adder output now reflects the operands captured at accept.
                    acc_d = add_res;
`ifdef FP16ACC_FLAGS_EN
                    pflags_d = pflags_q | res_flags;
`endif
                    if (last_q) begin
                        sum_d   = add_res;
                        count_d = cnt_q;
                        state_d = S_OUT;
`ifdef FP16ACC_FLAGS_EN
                        oflags_d = pflags_q | res_flags;
                        pflags_d = 2'b00;
`endif
                    end else begin
                        state_d = S_ACCEPT;
                    end
                end
            end
            S_OUT: begin
                if (i_rdy) begin
                    acc_d   = 16'h0000;
                    cnt_d   = '0;
                    state_d = S_ACCEPT;
`ifdef FP16ACC_FLAGS_EN
                    oflags_d = 2'b00;
`endif
                end
            end
            default: state_d = S_ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACCEPT;
            acc_q   <= 16'h0000;
            op_a_q  <= 16'h0000;
            op_b_q  <= 16'h0000;
            sum_q   <= 16'h0000;
            cnt_q   <= '0;
            count_q <= '0;
            wcnt_q  <= 3'd0;
            last_q  <= 1'b0;
`ifdef FP16ACC_FLAGS_EN
            pflags_q <= 2'b00;
            oflags_q <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            wcnt_q  <= wcnt_d;
            last_q  <= last_d;
`ifdef FP16ACC_FLAGS_EN
            pflags_q <= pflags_d;
            oflags_q <= oflags_d;
`endif
        end
    end

    assign o_vld   = (state_q == S_OUT);
    assign o_sum   = sum_q;
    assign o_count = count_q;
endmodule

// File: tb/tb_fp16acc_stream.sv
// ---------------------------------------------------------------------------
// tb_fp16acc_stream
//   Directed bench for fp16acc_stream with hand-computed FP16 sums.
//   Flag expectations follow FP16ACC_FLAGS_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_fp16acc_stream;
    localparam int LAT = 1;
    localparam int CW  = 8;
`ifdef FP16ACC_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_vld = 1'b0;
    logic          o_rdy;
    logic [15:0]   i_data = 16'h0000;
    logic          i_last = 1'b0;
    logic          o_vld;
    logic          i_rdy = 1'b1;
    logic [15:0]   o_sum;
    logic [CW-1:0] o_count;
    logic [1:0]    o_flags;

    int passes = 0;
    int total  = 0;
    int waited;
    int lat_n;
    logic [15:0]   got_sum;
    logic [CW-1:0] got_count;
    logic [1:0]    got_flags;
    logic [15:0]   hold_sum;
    logic [CW-1:0] hold_count;

    fp16acc_stream #(.ADD_LATENCY(LAT), .COUNT_WIDTH(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vld   (i_vld),
        .o_rdy   (o_rdy),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_vld   (o_vld),
        .i_rdy   (i_rdy),
        .o_sum   (o_sum),
        .o_count (o_count),
        .o_flags (o_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present one element and hold it until accepted; returns negedges spent waiting.
    task automatic send(input logic [15:0] d, input logic last, output int w);
        w = 0;
        @(negedge clk);
        i_vld = 1'b1; i_data = d; i_last = last;
        while (!o_rdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("rdy_seen", 32'(o_rdy), 32'd1);
        @(posedge clk);
        #1;
        i_vld = 1'b0; i_last = 1'b0;
    endtask

    // Called right after the last accept: measure edges to o_vld, capture outputs,
    // and complete the handshake when i_rdy is high.
    task automatic recv(output int n);
        n = 0;
        @(negedge clk);
        while (!o_vld && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        got_sum = o_sum; got_count = o_count; got_flags = o_flags;
        if (i_rdy) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_vld",   32'(o_vld),   32'd0);
        check("rst_rdy",   32'(o_rdy),   32'd1);
        check("rst_sum",   32'(o_sum),   32'h0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_flags", 32'(o_flags), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // 1.0 + 2.0 + 0.5 = 3.5, with ready spacing and output latency
        send(16'h3C00, 1'b0, waited);
        send(16'h4000, 1'b0, waited);
        check("rdy_gap1", 32'(waited), 32'(LAT + 1));
        send(16'h3800, 1'b1, waited);
        check("rdy_gap2", 32'(waited), 32'(LAT + 1));
        recv(lat_n);
        check("latency",  32'(lat_n),     32'(LAT + 1));
        check("p1_sum",   32'(got_sum),   32'h4300);
        check("p1_count", 32'(got_count), 32'd3);
        check("p1_flags", 32'(got_flags), 32'd0);

        // Single element passes through exactly
        send(16'h4200, 1'b1, waited);
        recv(lat_n);
        check("p2_sum",   32'(got_sum),   32'h4200);
        check("p2_count", 32'(got_count), 32'd1);

        // Exact cancellation gives +0
        send(16'h3C00, 1'b0, waited);
        send(16'hBC00, 1'b1, waited);
        recv(lat_n);
        check("p3_sum",   32'(got_sum),   32'h0000);
        check("p3_count", 32'(got_count), 32'd2);

        // Overflow to +inf
        send(16'h7BFF, 1'b0, waited);
        send(16'h7BFF, 1'b1, waited);
        recv(lat_n);
        check("p4_sum",   32'(got_sum),   32'h7C00);
        check("p4_flags", 32'(got_flags), FLAGS_ON ? 32'd1 : 32'd0);

        // inf + -inf = NaN
        send(16'h7C00, 1'b0, waited);
        send(16'hFC00, 1'b1, waited);
        recv(lat_n);
        check("p5_exp",   32'(got_sum[14:10]), 32'h1F);
        check("p5_man",   32'(|got_sum[9:0]),  32'd1);
        check("p5_flags", 32'(got_flags),      FLAGS_ON ? 32'd3 : 32'd0);

        // Clean packet after specials: flags cleared, accumulator cleared
        send(16'h3800, 1'b1, waited);
        recv(lat_n);
        check("p6_sum",   32'(got_sum),   32'h3800);
        check("p6_flags", 32'(got_flags), 32'd0);

        // -0 + -0 starting from the +0 accumulator yields +0
        send(16'h8000, 1'b0, waited);
        send(16'h8000, 1'b1, waited);
        recv(lat_n);
        check("negz_sum", 32'(got_sum), 32'h0000);

        // Denormal input is flushed to zero
        send(16'h0001, 1'b1, waited);
        recv(lat_n);
        check("daz_sum", 32'(got_sum), 32'h0000);

        // Backpressure: hold i_rdy low for 10 cycles while offering a stray element
        i_rdy = 1'b0;
        send(16'h3C00, 1'b0, waited);
        send(16'h3C00, 1'b1, waited);
        recv(lat_n);
        check("bp_vld0",  32'(o_vld),     32'd1);
        check("bp_sum",   32'(got_sum),   32'h4000);
        check("bp_count", 32'(got_count), 32'd2);
        hold_sum = o_sum; hold_count = o_count;
        i_vld = 1'b1; i_data = 16'h4800; i_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_vld",      32'(o_vld),   32'd1);
            check("bp_rdy",      32'(o_rdy),   32'd0);
            check("bp_sum_hold", 32'(o_sum),   32'(hold_sum));
            check("bp_cnt_hold", 32'(o_count), 32'(hold_count));
        end
        i_vld = 1'b0; i_last = 1'b0;
        i_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", 32'(o_vld), 32'd0);
        send(16'h3C00, 1'b1, waited);
        recv(lat_n);
        check("bp_after_sum",   32'(got_sum),   32'h3C00);
        check("bp_after_count", 32'(got_count), 32'd1);

        // Counter saturation: 300 x 1.0 = 300.0 (0x5CB0), count stops at 255
        for (int i = 0; i < 300; i++) begin
            send(16'h3C00, (i == 299) ? 1'b1 : 1'b0, waited);
        end
        recv(lat_n);
        check("sat_sum",   32'(got_sum),   32'h5CB0);
        check("sat_count", 32'(got_count), 32'd255);

        // Reset during WAIT of a 2-element packet
        send(16'h3C00, 1'b0, waited);
        send(16'h4000, 1'b1, waited);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld",   32'(o_vld),   32'd0);
        check("mid_rst_rdy",   32'(o_rdy),   32'd1);
        check("mid_rst_sum",   32'(o_sum),   32'h0);
        check("mid_rst_count", 32'(o_count), 32'd0);
        check("mid_rst_flags", 32'(o_flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h3C00, 1'b1, waited);
        recv(lat_n);
        check("post_rst_sum",   32'(got_sum),   32'h3C00);
        check("post_rst_count", 32'(got_count), 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
